// File: rtl/br_target_buf.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Lookup is combinational from state; updates and invalidates take effect at the clock edge.
module br_target_buf #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lk_pc,
  output logic            pred_hit,
  output logic            pred_take,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            inv
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  localparam logic [1:0] CTR_STRONG_T = 2'b11;
  localparam logic [1:0] CTR_WEAK_T   = 2'b10;
  localparam logic [1:0] CTR_STRONG_N = 2'b00;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic             unused_pc_low;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  // Byte offset within the instruction word never participates in indexing or tagging.
  assign unused_pc_low = ^{lk_pc[1:0], upd_pc[1:0]};

  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_take   = 1'b0;
    pred_target = '0;
    if (pred_hit) begin
      pred_take   = ctr_q[lk_idx][1];
      pred_target = target_q[lk_idx];
    end
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (inv) begin
      // Only valid bits are cleared; a concurrent update is dropped.
      valid_d = '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != CTR_STRONG_T) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          end
          target_d[upd_idx] = upd_target;
        end else if (ctr_q[upd_idx] != CTR_STRONG_N) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = CTR_WEAK_T;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_STRONG_T;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_br_target_buf.sv
// Directed bench for br_target_buf: a reference model feeds an expected-result queue
// that is popped and compared against the combinational lookup outputs.
module tb_br_target_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lk_pc;
  logic        pred_hit;
  logic        pred_take;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        inv;

  int checks = 0;
  int fails  = 0;

  logic [33:0] exp_q[$];

  logic        m_valid  [16];
  logic [25:0] m_tag    [16];
  logic [31:0] m_target [16];
  logic [1:0]  m_ctr    [16];

  br_target_buf #(.PC_W(32), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_pc      (lk_pc),
    .pred_hit   (pred_hit),
    .pred_take  (pred_take),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .inv        (inv)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_ctr[i]    = 2'b11;
    end
  endtask

  function automatic logic [33:0] model_lookup(input logic [31:0] pc);
    int idx;
    idx = int'(pc[5:2]);
    if (m_valid[idx] && m_tag[idx] == pc[31:6])
      return {1'b1, m_ctr[idx][1], m_target[idx]};
    return '0;
  endfunction

  task automatic model_apply(input logic v, input logic [31:0] pc, input logic t,
                             input logic [31:0] tgt, input logic iv);
    int idx;
    logic hit;
    idx = int'(pc[5:2]);
    hit = m_valid[idx] && m_tag[idx] == pc[31:6];
    if (iv) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (v) begin
      if (hit && t) begin
        if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
        m_target[idx] = tgt;
      end else if (hit) begin
        if (m_ctr[idx] != 2'b00) m_ctr[idx] = m_ctr[idx] - 2'd1;
      end else if (t) begin
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = pc[31:6];
        m_target[idx] = tgt;
        m_ctr[idx]    = 2'b10;
      end
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc);
    logic [33:0] got, exp;
    lk_pc = pc;
    exp_q.push_back(model_lookup(pc));
    #1;
    got = {pred_hit, pred_take, pred_target};
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s pc=%h got hit=%b take=%b tgt=%h exp hit=%b take=%b tgt=%h",
             tag, pc, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                           input logic iv);
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = t;
    upd_target = tgt;
    inv        = iv;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    model_apply(upd_valid, upd_pc, upd_taken, upd_target, inv);
    upd_valid = 1'b0;
    inv       = 1'b0;
  endtask

  task automatic step(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    drive_upd(pc, t, tgt, 1'b0);
    commit();
  endtask

  initial begin
    rst_n = 1'b0;
    lk_pc = '0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    inv = 1'b0;
    model_reset();
    lookup("reset", 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    lookup("post_reset", 32'h100);

    step(32'h100, 1'b1, 32'h200);
    lookup("alloc", 32'h100);
    step(32'h100, 1'b0, 32'h0);
    lookup("nt1_ctr01", 32'h100);
    step(32'h100, 1'b0, 32'h0);
    step(32'h100, 1'b0, 32'h0);
    lookup("nt3_ctr00", 32'h100);
    step(32'h100, 1'b1, 32'h204);
    lookup("t_ctr01", 32'h100);

    for (int i = 0; i < 5; i++) step(32'h100, 1'b1, 32'h200);
    lookup("sat_ctr11", 32'h100);
    step(32'h100, 1'b0, 32'h0);
    lookup("sat_nt_ctr10", 32'h100);

    step(32'h140, 1'b1, 32'h300);
    lookup("alias_old", 32'h100);
    lookup("alias_new", 32'h140);
    step(32'h180, 1'b0, 32'h999);
    lookup("nt_miss_keep", 32'h140);
    lookup("nt_miss_noalloc", 32'h180);
    lookup("low_bits_ignored", 32'h143);

    step(32'h104, 1'b1, 32'h400);
    step(32'h104, 1'b0, 32'h0);
    drive_upd(32'h104, 1'b1, 32'h404, 1'b0);
    lookup("hazard_same_cycle", 32'h104);
    commit();
    lookup("hazard_next_cycle", 32'h104);

    @(negedge clk);
    upd_valid = 1'b0;
    upd_pc = 32'h10C;
    upd_taken = 1'b1;
    upd_target = 32'h777;
    commit();
    lookup("upd_valid_low", 32'h10C);

    drive_upd(32'h108, 1'b1, 32'h500, 1'b1);
    commit();
    lookup("inv_100", 32'h100);
    lookup("inv_104", 32'h104);
    lookup("inv_108", 32'h108);
    lookup("inv_140", 32'h140);
    step(32'h100, 1'b1, 32'h200);
    lookup("realloc", 32'h100);
    step(32'h100, 1'b0, 32'h0);
    lookup("realloc_ctr01", 32'h100);

    step(32'h10C, 1'b1, 32'h600);
    drive_upd(32'h110, 1'b1, 32'h700, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    lookup("async_reset_10C", 32'h10C);
    upd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lookup("after_reset_10C", 32'h10C);
    lookup("after_reset_110", 32'h110);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/br_target_buf.md
Name: br_target_buf

Overview:
- Direct-mapped branch target buffer (BTB) combined with a per-entry 2-bit saturating direction counter.
- Sits upstream of the branch direction logic, in the fetch stage. Fetch presents a PC every cycle and receives, in the same cycle, a hit flag, a taken/not-taken prediction and a target.
- Execute sends resolved branch outcomes back through the update port. Updates train the counters, allocate new entries and write targets.

Parameters:
- PC_W, 32, width of PC and target addresses.
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W = 16.
- TAG_W, PC_W-IDX_W-2 (derived, not overridable), tag width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset; asynchronous, active-low.
- lk_pc, input, PC_W, fetch PC for lookup.
- pred_hit, output, 1, valid entry with matching tag for lk_pc.
- pred_take, output, 1, predict taken (pred_hit & ctr[1]).
- pred_target, output, PC_W, stored target; all-zero when pred_hit=0.
- upd_valid, input, 1, resolved-branch update strobe.
- upd_pc, input, PC_W, PC of the resolved branch.
- upd_taken, input, 1, actual branch outcome.
- upd_target, input, PC_W, actual target; meaningful only when upd_taken=1.
- inv, input, 1, synchronous invalidate of all entries (context switch / self-modifying code).

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[PC_W-1:IDX_W+2]
  - pc[1:0] is ignored.
- Per-entry state, all flops: valid (1), tag (TAG_W), target (PC_W), ctr (2).
- Counter encoding:
  - 2'b11 strongly taken; 2'b10 weakly taken; 2'b01 weakly not taken; 2'b00 strongly not taken.
  - Predict taken iff ctr[1]=1.
- Reset (async, rst_n=0):
  - All valid=0, all ctr=2'b11, all tag=0, all target=0.
  - Outputs while in reset: pred_hit=0, pred_take=0, pred_target=0.
- Lookup is purely combinational from the state flops (zero latency):
  - pred_hit = valid[idx] & (tag[idx]==lk_tag).
  - When pred_hit=0: pred_take=0 and pred_target=0.
- Update is registered on the posedge with upd_valid=1. Define hit_u = valid[idx_u] & tag match.
  - hit_u & upd_taken: ctr increments, saturating at 2'b11; target <= upd_target.
  - hit_u & !upd_taken: ctr decrements, saturating at 2'b00; target unchanged.
  - !hit_u & upd_taken (cold miss or tag conflict): allocate/replace. valid<=1, tag<=upd tag, target<=upd_target, ctr<=2'b10.
  - !hit_u & !upd_taken: no state change (no allocation for not-taken branches).
- inv=1 at a posedge:
  - Every valid bit <= 0. Counters, tags and targets are untouched.
  - inv has priority: any upd_valid in the same cycle is dropped entirely.
- Same-cycle lookup and update to the same index:
  - Lookup returns the pre-update state; there is no write-to-read bypass.
  - The new state is visible from the next cycle.
- Only one update per cycle. Entries at other indices are never modified by an update.
- An update with upd_valid=0 has no effect, whatever the other upd_* values.
- Reset asserted mid-operation clears immediately and asynchronously; any in-flight update is lost.

Test Plan:
1. Reset, then lk_pc=0x100 -> pred_hit=0, pred_take=0, pred_target=0.
2. Allocate: update pc=0x100 with taken, target 0x200; next cycle lk_pc=0x100 -> hit=1, take=1, target=0x200 (ctr=10). Then:
   - One not-taken update -> take=0 (ctr=01).
   - Two more not-taken -> ctr=00.
   - One taken -> ctr=01, take=0.
3. Saturation: five taken updates to 0x100 -> ctr=11. One not-taken -> ctr=10, take still 1.
4. Alias conflict: with 0x100 resident, update pc=0x140 (same index 0, different tag) with taken, target 0x300.
   - lk_pc=0x100 -> hit=0.
   - lk_pc=0x140 -> hit=1, target=0x300, ctr=10.
   - A not-taken update to 0x180 (miss) leaves 0x140 intact.
5. Same-cycle hazard: with 0x104 at ctr=01, lookup 0x104 while updating it taken -> take=0 that cycle, take=1 next cycle.
6. inv together with upd_valid (taken, pc 0x108) -> all lookups miss afterwards, including 0x108. Re-allocating 0x100 restores hit with ctr=10.
